// File: rtl/pipe_pkg.sv
// Shared types for the fetch/decode pipeline register.
// The fetch_t widths match the default XLEN/ILEN of 32.
package pipe_pkg;

  localparam int unsigned PKG_XLEN = 32;
  localparam int unsigned PKG_ILEN = 32;

  // Canonical RISC-V NOP: addi x0, x0, 0
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PKG_ILEN-1:0] instr;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pc_inc;
  } fetch_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg_skid_buffer.sv
// Two-entry skid buffer, generic over payload type T.
// in_ready comes from a flop, so out_ready never reaches it combinationally.
module skid_buffer
  import pipe_pkg::*;
#(
  parameter type T = fetch_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  skid_state_e state_q, state_d;
  T            main_q, main_d;
  T            skid_q, skid_d;
  logic        ready_q;
  logic        in_beat;
  logic        out_beat;

  assign in_beat  = valid_i && ready_q;
  assign out_beat = (state_q != ST_EMPTY) && ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_beat) begin
            state_d = ST_BUSY;
            main_d  = data_i;
          end
        end
        ST_BUSY: begin
          if (in_beat && !out_beat) begin
            state_d = ST_FULL;
            skid_d  = data_i;
          end else if (in_beat) begin
            main_d = data_i;
          end else if (out_beat) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_beat) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  // Flush drops whatever is offered, so the upstream may always retire it.
  assign ready_o = ready_q || flush_i;
  assign valid_o = (state_q != ST_EMPTY);
  assign data_o  = main_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// IF/ID pipeline register with flush and a stall performance counter.
// Define PIPE_STAGE_SKID_EN to use a registered-ready skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     CNT_W     = 16,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(RV_NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ILEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc_inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_inc,
  input  logic             flush,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
  } payload_t;

  payload_t         in_pay;
  payload_t         out_pay;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_pay = '{instr: in_instr, pc: in_pc, pc_inc: in_pc_inc};

`ifdef PIPE_STAGE_SKID_EN
  skid_buffer #(
    .T(payload_t)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush),
    .valid_i(in_valid),
    .ready_o(in_ready),
    .data_i (in_pay),
    .valid_o(out_valid),
    .ready_i(out_ready),
    .data_o (out_pay)
  );
`else
  payload_t main_q, main_d;
  logic     valid_q, valid_d;

  assign in_ready = flush || !valid_q || out_ready;

  // Payload is kept on flush so pc/pc_inc stay observable.
  always_comb begin
    main_d  = main_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      main_d  = in_pay;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      main_q  <= main_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pay   = main_q;
`endif

  assign out_instr  = out_valid ? out_pay.instr : NOP_INSTR;
  assign out_pc     = out_pay.pc;
  assign out_pc_inc = out_pay.pc_inc;

  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue reference model.
// Works for both builds (PIPE_STAGE_SKID_EN defined or not).
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CMAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_pc_inc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_inc;
  logic        flush = 1'b0;
  logic        stall_clr = 1'b0;
  logic [3:0]  stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] inc;
  } beat_t;

  beat_t q[$];
  int    cnt = 0;
  bit    acc;

  pipe_stage_reg #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_pc_inc (in_pc_inc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pc_inc(out_pc_inc),
    .flush     (flush),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    if (flush) return 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  task automatic put(input bit v, input logic [31:0] pc);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {pc[15:0], 16'h0033};
    in_pc_inc = pc + 32'd4;
  endtask

  // Advance one clock, updating the reference model from pre-edge inputs.
  task automatic tick(output bit a);
    bit    pop;
    beat_t b;
    a   = in_valid && m_ready() && !flush;
    pop = (q.size() > 0) && out_ready;
    b   = '{in_instr, in_pc, in_pc_inc};
    if (stall_clr) cnt = 0;
    else if (q.size() > 0 && !out_ready && cnt < CMAX) cnt++;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (a) q.push_back(b);
    end
    #1;
  endtask

  task automatic clr_cnt();
    stall_clr = 1'b1;
    tick(acc);
    stall_clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0 ||
        out_pc_inc !== 32'h0 || stall_cnt !== 4'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init: v=%b i=%h pc=%h inc=%h cnt=%0d rdy=%b want 0 13 0 0 0 1",
               out_valid, out_instr, out_pc, out_pc_inc, stall_cnt, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b0;
    put(1'b1, 32'h80);
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    n_tests++;
    if (out_valid !== 1'b1 || stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_setup: v=%b cnt=%0d want 1 1", out_valid, stall_cnt);
    end
    put(1'b1, 32'h84);
    #1 rst = 1'b1;
    q.delete();
    cnt = 0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== NOP || stall_cnt !== 4'd0 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: v=%b i=%h cnt=%0d pc=%h want 0 13 0 0",
               out_valid, out_instr, stall_cnt, out_pc);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: out_valid=%b want 0", out_valid);
    end
    #1 rst = 1'b0;
    out_ready = 1'b1;
    put(1'b1, 32'h40);
    tick(acc);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h0040_0033) begin
      n_fail++;
      $display("FAIL reset_first_edge: v=%b pc=%h i=%h want 1 40 00400033",
               out_valid, out_pc, out_instr);
    end
    tick(acc);
  endtask

  task automatic test_throughput();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      put(1'b1, 32'(k * 4));
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL thru_ready[%0d]: in_ready=%b want 1", k, in_ready);
      end
      tick(acc);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'(k * 4) || out_pc_inc !== 32'(k * 4 + 4)) begin
        n_fail++;
        $display("FAIL thru_out[%0d]: v=%b pc=%h inc=%h want 1 %h %h",
                 k, out_valid, out_pc, out_pc_inc, k * 4, k * 4 + 4);
      end
    end
    in_valid = 1'b0;
    tick(acc);
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== NOP) begin
      n_fail++;
      $display("FAIL thru_drain: v=%b i=%h want 0 13", out_valid, out_instr);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    clr_cnt();
    out_ready = 1'b0;
    put(1'b1, 32'h10);
    tick(acc);
    put(1'b1, 32'h14);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h0010_0033) begin
        n_fail++;
        $display("FAIL bp_stable[%0d]: v=%b pc=%h i=%h want 1 10 00100033",
                 k, out_valid, out_pc, out_instr);
      end
      tick(acc);
      if (acc) in_valid = 1'b0;
    end
    n_tests++;
    if (out_pc !== 32'h10 || stall_cnt !== 4'd3 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: pc=%h cnt=%0d rdy=%b want 10 3 0", out_pc, stall_cnt, in_ready);
    end
    out_ready = 1'b1;
    tick(acc);
    if (acc) in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h14 || out_pc_inc !== 32'h18) begin
      n_fail++;
      $display("FAIL bp_second: v=%b pc=%h inc=%h want 1 14 18", out_valid, out_pc, out_pc_inc);
    end
    in_valid = 1'b0;
    tick(acc);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    clr_cnt();
    out_ready = 1'b0;
    put(1'b1, 32'h20);
    tick(acc);
    put(1'b1, 32'h24);
    tick(acc);
    put(1'b1, 32'h28);
    flush = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: in_ready=%b want 1", in_ready);
    end
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h20 ||
        out_pc_inc !== 32'h24 || stall_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL flush_out: v=%b i=%h pc=%h inc=%h cnt=%0d want 0 13 20 24 2",
               out_valid, out_instr, out_pc, out_pc_inc, stall_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_ghost[%0d]: v=%b pc=%h want 0", k, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_saturation();
    clr_cnt();
    out_ready = 1'b0;
    put(1'b1, 32'h30);
    tick(acc);
    in_valid = 1'b0;
    repeat (20) tick(acc);
    n_tests++;
    if (stall_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_max: stall_cnt=%0d want 15", stall_cnt);
    end
    stall_clr = 1'b1;
    tick(acc);
    stall_clr = 1'b0;
    n_tests++;
    if (stall_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_clr: stall_cnt=%0d want 0", stall_cnt);
    end
    tick(acc);
    n_tests++;
    if (stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_restart: stall_cnt=%0d want 1", stall_cnt);
    end
    out_ready = 1'b1;
    tick(acc);
    n_tests++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_drain: v=%b cnt=%0d want 0 1", out_valid, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        in_valid  = ($urandom_range(0, 99) < 65);
        in_instr  = $urandom;
        in_pc     = $urandom & 32'hffff_fffc;
        in_pc_inc = in_pc + 32'd4;
      end
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      stall_clr = ($urandom_range(0, 99) < 4);
      #1;
      n_tests++;
      if (in_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: in_ready=%b want %b", c, in_ready, m_ready());
      end
      n_tests++;
      if (out_valid !== (q.size() > 0) || stall_cnt !== 4'(cnt)) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: v=%b cnt=%0d want %b %0d",
                 c, out_valid, stall_cnt, q.size() > 0, cnt);
      end
      n_tests++;
      if (q.size() > 0) begin
        if (out_instr !== q[0].instr || out_pc !== q[0].pc || out_pc_inc !== q[0].inc) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: i=%h pc=%h inc=%h want %h %h %h", c,
                   out_instr, out_pc, out_pc_inc, q[0].instr, q[0].pc, q[0].inc);
        end
      end else if (out_instr !== NOP) begin
        n_fail++;
        $display("FAIL rand_nop[%0d]: out_instr=%h want 13", c, out_instr);
      end
      tick(acc);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
    out_ready = 1'b1;
    tick(acc);
    tick(acc);
    n_tests++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_final: v=%b model=%0d want 0 0", out_valid, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of the pc and pc_inc fields.
REQ-002 SHALL have parameter ILEN, default 32, width of the instruction field.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction driven while the stage is empty or flushed.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-008 SHALL have ports in_instr (input, ILEN), in_pc (input, XLEN) and in_pc_inc (input, XLEN), the upstream payload.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-010 SHALL have ports out_instr (output, ILEN), out_pc (output, XLEN) and out_pc_inc (output, XLEN), the registered payload.
REQ-011 SHALL have port flush (input, 1), a synchronous squash of all held beats.
REQ-012 SHALL have ports stall_clr (input, 1) and stall_cnt (output, CNT_W), the stall performance counter and its clear.

Function
REQ-013 SHALL transfer a beat upstream when in_valid && in_ready and downstream when out_valid && out_ready, both sampled at the rising clk edge.
REQ-014 SHALL give a latency of exactly 1 cycle from upstream acceptance to out_valid when the stage is empty and not stalled.
REQ-015 SHALL keep out_* payload and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL never drop or duplicate a beat except on flush, and SHALL deliver beats in order.
REQ-017 SHALL give flush priority over every other event: next cycle out_valid=0, every held beat (main and skid) discarded, out_instr=NOP_INSTR, out_pc and out_pc_inc held.
REQ-018 SHALL hold in_ready=1 during a flush cycle, and SHALL drop any beat presented in that cycle.
REQ-019 SHALL drive out_instr=NOP_INSTR whenever out_valid=0.
REQ-020 SHALL increment stall_cnt by 1 in each cycle with out_valid && !out_ready, saturating at all-ones with no wrap.
REQ-021 SHALL clear stall_cnt to 0 on stall_clr, with stall_clr taking priority over an increment in the same cycle.
REQ-022 SHALL leave stall_cnt unchanged by flush.

Reset
REQ-023 SHALL, on rst high and independent of clk, drive out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_inc=0, stall_cnt=0, skid empty and in_ready=1.
REQ-024 SHALL discard any beat in flight when rst asserts mid-transfer, and SHALL accept nothing while rst is high.
REQ-025 SHALL accept a beat in the first clk edge after rst deasserts.

Configuration
REQ-026 SHALL use macro PIPE_STAGE_SKID_EN to select the skid buffer.
REQ-027 SHALL, with PIPE_STAGE_SKID_EN undefined, drive in_ready = !out_valid || out_ready combinationally, with a single payload register.
REQ-028 SHALL, with PIPE_STAGE_SKID_EN defined, drive in_ready from a flop (in_ready = !skid_full) with no combinational path from out_ready.
REQ-029 SHALL, with PIPE_STAGE_SKID_EN defined, implement states EMPTY, BUSY (main full) and FULL (main plus skid full).
REQ-030 SHALL implement EMPTY->BUSY on an input beat.
REQ-031 SHALL implement BUSY->FULL on an input beat with no output beat.
REQ-032 SHALL implement BUSY->EMPTY on an output beat with no input beat.
REQ-033 SHALL stay in BUSY on simultaneous input and output beats.
REQ-034 SHALL implement FULL->BUSY on an output beat, moving the skid beat into main.
REQ-035 SHALL send any state to EMPTY on flush.
REQ-036 SHALL, in both configurations, sustain 1 beat/cycle when out_ready is held high.

Structure
REQ-037 SHALL place in shared package pipe_pkg: the NOP_INSTR constant, the fetch payload struct typedef (instr, pc, pc_inc) and the skid state enum.
REQ-038 SHALL be built on one sub-module, skid_buffer, generic over payload type, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-039 SHALL cover reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, out_instr=32'h13, stall_cnt=0 immediately, without a clk edge.
REQ-040 SHALL cover throughput: stream pc=0x0,0x4,0x8 with out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles, each 1 cycle after acceptance.
REQ-041 SHALL cover backpressure: hold out_ready=0 for 3 cycles with beat pc=0x10 -> payload stable, stall_cnt=3, and (skid build) second beat pc=0x14 absorbed, in_ready=0, both delivered in order.
REQ-042 SHALL cover flush: assert flush while FULL with in_valid=1 -> next cycle out_valid=0, out_instr=32'h13, and the in-flight beat never appears.
REQ-043 SHALL cover counter saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15; stall_clr together with a stall -> 0.
REQ-044 SHALL cover random valid/ready in both builds against a reference queue model -> zero mismatches, no loss, no duplication.
